// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator: emits exactly |speed_cmd| evenly spaced
// steps per window of WINDOW_CYCLES clocks, forward or reverse by sign.
// Ports: clk, reset (async, active-high), speed_cmd/cmd_valid (command),
// outA/outB (registered quadrature), window_start (first cycle of window),
// active_speed (speed being emitted), position (cumulative steps).
// Option: define QUADGEN_POSITION_EN to build the position counter;
// otherwise position is tied to zero.
module quad_encoder_emulator #(
    parameter int WINDOW_CYCLES = 1250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] speed_cmd,
    input  logic        cmd_valid,
    output logic        outA,
    output logic        outB,
    output logic        window_start,
    output logic [15:0] active_speed,
    output logic [31:0] position
);

    localparam int CW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int AW = ($clog2(WINDOW_CYCLES) + 2 > 18) ?
                        $clog2(WINDOW_CYCLES) + 2 : 18;
    localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 1);
    localparam logic [AW-1:0] WC   = AW'(WINDOW_CYCLES);

    logic [15:0]   pending;
    logic [CW-1:0] win_cnt;
    logic [AW-1:0] acc;
    logic          run;

    logic [16:0]   ext;
    logic [16:0]   mag;
    logic [AW-1:0] sum;
    logic          step;
    logic          fwd;
    logic          last;

    // Bresenham-style spreading: acc wraps by WINDOW_CYCLES once per step,
    // and lands on exactly 0 at the window end.
    always_comb begin
        ext  = {active_speed[15], active_speed};
        mag  = active_speed[15] ? (~ext + 17'd1) : ext;
        sum  = acc + AW'(mag);
        step = run && (sum >= WC);
        fwd  = ~active_speed[15];
        last = run && (win_cnt == LAST);
    end

    // run marks that the first window has begun; the clock edge after
    // reset release starts window 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run          <= 1'b0;
            pending      <= '0;
            active_speed <= '0;
            win_cnt      <= '0;
            acc          <= '0;
        end else begin
            run <= 1'b1;
            if (cmd_valid)
                pending <= speed_cmd;
            if (last) begin
                win_cnt      <= '0;
                acc          <= '0;
                active_speed <= cmd_valid ? speed_cmd : pending;
            end else if (run) begin
                win_cnt <= win_cnt + CW'(1);
                acc     <= step ? (sum - WC) : sum;
            end
        end
    end

    // Gray sequence {A,B}: forward 00->10->11->01, reverse the opposite.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outA <= 1'b0;
            outB <= 1'b0;
        end else if (step) begin
            outA <= fwd ? ~outB : outB;
            outB <= fwd ? outA : ~outA;
        end
    end

    assign window_start = run && (win_cnt == '0);

`ifdef QUADGEN_POSITION_EN
    logic [31:0] pos_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pos_q <= '0;
        else if (step)
            pos_q <= fwd ? (pos_q + 32'd1) : (pos_q - 32'd1);
    end

    assign position = pos_q;
`else
    assign position = '0;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench for quad_encoder_emulator: a W=16 instance checked
// every cycle against a step-count model, and a W=32768 full-speed instance.
module tb_quad_encoder_emulator;

    localparam int W  = 16;
    localparam int WB = 32768;
`ifdef QUADGEN_POSITION_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        val_a = 1'b0;
    logic        val_b = 1'b0;
    logic        a_a, b_a, ws_a;
    logic        a_b, b_b, ws_b;
    logic [15:0] act_a, act_b;
    logic [31:0] pos_a, pos_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    quad_encoder_emulator #(.WINDOW_CYCLES(W)) dut_a (
        .clk(clk), .reset(rst), .speed_cmd(cmd_a), .cmd_valid(val_a),
        .outA(a_a), .outB(b_a), .window_start(ws_a),
        .active_speed(act_a), .position(pos_a)
    );

    quad_encoder_emulator #(.WINDOW_CYCLES(WB)) dut_b (
        .clk(clk), .reset(rst), .speed_cmd(cmd_b), .cmd_valid(val_b),
        .outA(a_b), .outB(b_b), .window_start(ws_b),
        .active_speed(act_b), .position(pos_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: window index, commanded speeds, and steps completed in
    // earlier windows. Steps within a window follow floor(c*k/W).
    logic               m_run  = 1'b0;
    int                 m_wc   = 0;
    logic signed [15:0] m_pend = '0;
    logic signed [15:0] m_act  = '0;
    longint             m_base = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_wc   <= 0;
            m_pend <= '0;
            m_act  <= '0;
            m_base <= 0;
        end else begin
            if (!m_run) begin
                m_run <= 1'b1;
            end else if (m_wc == W - 1) begin
                m_base <= m_base + longint'(m_act);
                m_wc   <= 0;
                m_act  <= val_a ? cmd_a : m_pend;
            end else begin
                m_wc <= m_wc + 1;
            end
            if (val_a)
                m_pend <= cmd_a;
        end
    end

    function automatic longint cnt_now();
        longint k;
        longint q;
        k = (m_act < 0) ? -longint'(m_act) : longint'(m_act);
        q = (longint'(m_wc) * k) / W;
        return m_base + ((m_act < 0) ? -q : q);
    endfunction

    function automatic logic [1:0] ab_of(input longint c);
        int r;
        r = int'(((c % 4) + 4) % 4);
        case (r)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    always @(negedge clk) begin
        longint c;
        c = cnt_now();
        chk("ab", {30'd0, a_a, b_a}, {30'd0, ab_of(c)});
        chk("ws", {31'd0, ws_a}, {31'd0, (m_run && m_wc == 0)});
        chk("act", {16'd0, act_a}, {16'd0, m_act});
        chk("pos", pos_a, POS_EN ? 32'(c) : 32'd0);
    end

    task automatic pulse_a(input logic [15:0] v);
        @(posedge clk);
        #1 cmd_a = v;
        val_a = 1'b1;
        @(posedge clk);
        #1 val_a = 1'b0;
    endtask

    task automatic wait_window();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_run && m_wc == 0) && n < 64);
        if (!(m_run && m_wc == 0))
            chk("wait_window_timeout", 32'(n), 32'd0);
    endtask

    task automatic expect_at(input int wc, input logic [1:0] ab,
                             input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_wc != wc && n < 64);
        chk({nm, "_reach"}, 32'(m_wc), 32'(wc));
        chk({nm, "_dut"}, {30'd0, a_a, b_a}, {30'd0, ab});
        chk({nm, "_model"}, {30'd0, ab_of(cnt_now())}, {30'd0, ab});
    endtask

    initial begin
        int n;
        logic [1:0]  prev;
        logic [1:0]  cur;
        logic [31:0] pos0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // idle: no command, window_start every 16 cycles
        wait_window();
        chk("idle_act", {16'd0, act_a}, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ws_a && n < 40);
        chk("ws_period", 32'(n), 32'd16);
        chk("idle_ab", {30'd0, a_a, b_a}, 32'd0);

        // +4 per window
        pulse_a(16'd4);
        wait_window();
        chk("act4", {16'd0, act_a}, 32'd4);
        expect_at(3, 2'b00, "p4_c3");
        expect_at(4, 2'b10, "p4_c4");
        expect_at(8, 2'b11, "p4_c8");
        expect_at(12, 2'b01, "p4_c12");
        expect_at(0, 2'b00, "p4_end");
        chk("pos4", pos_a, POS_EN ? 32'd4 : 32'd0);

        // -3 per window
        pulse_a(16'hFFFD);
        wait_window();
        chk("act_m3", {16'd0, act_a}, 32'h0000FFFD);
        expect_at(5, 2'b00, "m3_c5");
        expect_at(6, 2'b01, "m3_c6");
        expect_at(11, 2'b11, "m3_c11");
        expect_at(0, 2'b10, "m3_end");
        chk("pos_m3", pos_a, POS_EN ? 32'd5 : 32'd0);

        // +5 strobed mid-window while emitting +2
        pulse_a(16'd2);
        wait_window();
        chk("act2", {16'd0, act_a}, 32'd2);
        expect_at(5, 2'b11, "p2_c5");
        pulse_a(16'd5);
        expect_at(10, 2'b01, "p2_c10");
        chk("act2_hold", {16'd0, act_a}, 32'd2);
        expect_at(0, 2'b00, "p2_end");
        chk("act5", {16'd0, act_a}, 32'd5);
        chk("pos_p2", pos_a, POS_EN ? 32'd4 : 32'd0);
        expect_at(4, 2'b10, "p5_c4");
        expect_at(7, 2'b11, "p5_c7");
        expect_at(13, 2'b00, "p5_c13");
        expect_at(0, 2'b10, "p5_end");
        chk("pos_p5", pos_a, POS_EN ? 32'd9 : 32'd0);

        // async reset while at phase 11
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ({a_a, b_a} != 2'b11 && n < 40);
        chk("reach_11", {30'd0, a_a, b_a}, 32'd3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_ab", {30'd0, a_a, b_a}, 32'd0);
        chk("rst_ws", {31'd0, ws_a}, 32'd0);
        chk("rst_act", {16'd0, act_a}, 32'd0);
        chk("rst_pos", pos_a, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_window();
        wait_window();
        chk("rst_pend_cleared", {16'd0, act_a}, 32'd0);
        pulse_a(16'd4);
        wait_window();
        expect_at(4, 2'b10, "re_c4");
        expect_at(8, 2'b11, "re_c8");

        // full speed reverse, one step every cycle
        @(posedge clk);
        #1 cmd_b = 16'h8000;
        val_b = 1'b1;
        @(posedge clk);
        #1 val_b = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ws_b && n < 40000);
        chk("b_ws_found", {31'd0, ws_b}, 32'd1);
        chk("b_act", {16'd0, act_b}, 32'h00008000);
        prev = {a_b, b_b};
        chk("b_start_ab", {30'd0, prev}, 32'd0);
        pos0 = pos_b;
        for (int i = 1; i <= WB; i++) begin
            @(negedge clk);
            cur = {a_b, b_b};
            chk("b_rev_step", {30'd0, cur}, {30'd0, prev[0], ~prev[1]});
            prev = cur;
        end
        chk("b_ws_next", {31'd0, ws_b}, 32'd1);
        chk("b_end_ab", {30'd0, prev}, 32'd0);
        chk("b_pos", pos_b, POS_EN ? (pos0 - 32'd32768) : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quad_encoder_emulator.md
# quad_encoder_emulator

Generates quadrature A/B signals from a commanded signed speed, so the motor speed-measurement path can be driven closed-loop in the FPGA without a physical motor. A speed command is given in quadrature steps per measurement window (one step = one A or B edge), and exactly that many steps are emitted per window, evenly spaced. Outputs feed the speed decoder's A/B inputs in place of the real encoder pins, on bench builds.

## Interface
- WINDOW_CYCLES, 1250000: clock cycles per window (25 ms at 50 MHz); must be ≥ 32768.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- speed_cmd  in  16  signed speed command, steps per window; positive = forward
- cmd_valid  in  1  one-cycle strobe; speed_cmd captured when high
- outA  out  1  quadrature channel A (registered)
- outB  out  1  quadrature channel B (registered)
- window_start  out  1  one-cycle pulse on first cycle of each window
- active_speed  out  16  signed speed currently being emitted
- position  out  32  signed cumulative step count (see Configuration)

## Operation
- Registers: pending (16b signed), active_speed, win_cnt (0..WINDOW_CYCLES-1), acc (≥18b unsigned), 2-bit phase {A,B}.
- cmd_valid=1: pending <= speed_cmd. Last strobe before a window boundary wins.
- Window boundary = cycle where win_cnt == WINDOW_CYCLES-1. On that edge: win_cnt <= 0, active_speed <= pending (or speed_cmd if cmd_valid that same cycle), acc <= 0.
- mag = |active_speed|, 17 bits; -32768 gives 32768.
- Each cycle: sum = acc + mag. If sum ≥ WINDOW_CYCLES: acc <= sum - WINDOW_CYCLES, one step emitted. Else acc <= sum.
- acc returns to 0 exactly at window end, so each window emits exactly mag steps; steps no closer than one per cycle.
- Forward sequence of {A,B}: 00 → 10 → 11 → 01 → 00. Reverse sequence is the opposite order. Exactly one of A/B toggles per step.
- Direction sign: the decoder counts A-rising-while-B-low as +1, so positive speed yields a positive measured speed.
- active_speed = 0: outputs hold their phase, no edges.
- Direction change at a boundary: continues from current phase, no jump.

## Timing
- Reset (async): outA=0, outB=0, window_start=0, active_speed=0, pending=0, win_cnt=0, acc=0, position=0.
- Reset mid-step forces {A,B}=00 immediately, even if this is a non-adjacent transition.
- After reset release, the first window begins at the first clock edge. window_start=1 in the cycle win_cnt==0, including the first cycle after reset.
- Command latency: takes effect at the next window boundary, never mid-window.
- Step latency: outA/outB change on the clock edge that ends the cycle in which the step condition holds. No combinational path from inputs to outA/outB.
- Steps in a window with mag=k, window W: step n (1-based) occurs at the end of cycle ceil(n·W/k)-1 of the window.

## Configuration
- QUADGEN_POSITION_EN defined:
  - position increments by 1 per forward step and decrements by 1 per reverse step, on the same edge as the A/B change.
  - Wraps modulo 2^32.
  - Reset value 0.
- QUADGEN_POSITION_EN undefined:
  - Position counter not synthesised.
  - position tied to 32'b0.
  - All other behaviour identical.

## Test plan
- Reset release with WINDOW_CYCLES=16 and no command -> outA=outB=0 forever; window_start pulses every 16 cycles; active_speed=0.
- WINDOW_CYCLES=16, cmd +4, next window -> {A,B} 10,11,01,00 at ends of window cycles 3,7,11,15; position +4 per window.
- cmd -3, WINDOW_CYCLES=16 -> reverse steps 01,11,10 at ends of cycles 5,10,15; position -3 per window.
- Command +5 strobed mid-window while emitting +2 -> current window emits exactly 2 steps; next window emits 5; active_speed changes only at the boundary.
- WINDOW_CYCLES=32768, cmd -32768 -> one reverse step every cycle; 32768 steps per window; no skipped phase.
- Async reset asserted mid-window at phase 11 -> outputs 00 immediately; all registers at reset values; emission restarts cleanly.
